// File: rtl/edm_pkg.sv
// Shared types and constants for the EDM discharge-pulse timing engine.
package edm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } pg_state_t;

  localparam logic [1:0] PG_TON  = 2'd0;
  localparam logic [1:0] PG_TOFF = 2'd1;
  localparam logic [1:0] PG_MASK = 2'd2;
  localparam logic [1:0] PG_MODE = 2'd3;

  localparam int   PG_TON_RST  = 100;
  localparam int   PG_TOFF_RST = 400;
  localparam logic PG_MODE_RST = 1'b0;

endpackage

// File: rtl/next_chan_sel.sv
// Finds the next set mask bit strictly after idx, wrapping around; returns idx
// itself only when that is the sole set bit, and idx when the mask is empty.
module next_chan_sel #(
  parameter int N_CH = 2,
  parameter int PW   = 1
) (
  input  logic [N_CH-1:0] mask,
  input  logic [PW-1:0]   idx,
  output logic [PW-1:0]   sel
);

  logic [N_CH-1:0] sh;
  int              j;

  // Walk from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    sel = idx;
    sh  = '0;
    j   = 0;
    for (int i = N_CH; i >= 1; i--) begin
      j  = (int'(idx) + i) % N_CH;
      sh = mask >> j;
      if (sh[0]) sel = PW'(j);
    end
  end

endmodule

// File: rtl/multi_channel_pulse_gen.sv
// Ton/Toff discharge-pulse engine: N_CH gate enables, deion strobe in Toff,
// parallel or round-robin channels, config double-buffered to period bounds.
module multi_channel_pulse_gen
  import edm_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CNT_W = 16,
  parameter int DEAD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [N_CH-1:0]  pulse,
  output logic             deion,
  output logic             is_operation,
  output logic             period_done
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  pg_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] ton_s, toff_s, ton_w, toff_w, toff_a, toff_nx;
  logic [N_CH-1:0]  mask_s, mask_w, mask_a, mask_nx;
  logic             mode_s, mode_w, mode_a, mode_nx;
  logic [PW-1:0]    ptr, ptr_nx, sel, sel_idx;
  logic             load;
  logic [N_CH-1:0]  pulse_d;
  logic             deion_d, done_d;
  int               toff_e;

  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  next_chan_sel #(.N_CH(N_CH), .PW(PW)) u_sel (
    .mask (mask_w),
    .idx  (sel_idx),
    .sel  (sel)
  );

  // Staging view including a write in this very cycle, so boundary loads see it.
  always_comb begin
    ton_w  = ton_s;
    toff_w = toff_s;
    mask_w = mask_s;
    mode_w = mode_s;
    if (cfg_we) begin
      case (cfg_addr)
        PG_TON:  ton_w  = cfg_data;
        PG_TOFF: toff_w = cfg_data;
        PG_MASK: mask_w = cfg_data[N_CH-1:0];
        default: mode_w = cfg_data[0];
      endcase
    end
  end

  assign sel_idx = (state == IDLE) ? PW'(N_CH - 1) : ptr;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    load     = 1'b0;
    case (state)
      IDLE: begin
        load = 1'b1;
        if (start && (mask_w != '0)) begin
          state_nx = ON;
          cnt_nx   = len_m1(ton_w);
          ptr_nx   = sel;
        end
      end
      ON: begin
        if (cnt == '0) begin
          state_nx = OFF;
          cnt_nx   = len_m1(toff_a);
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      OFF: begin
        if (cnt == '0) begin
          load = 1'b1;
          if (mask_w != '0) begin
            state_nx = ON;
            cnt_nx   = len_m1(ton_w);
            ptr_nx   = sel;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    if (stop) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end

  assign toff_nx = load ? toff_w : toff_a;
  assign mask_nx = load ? mask_w : mask_a;
  assign mode_nx = load ? mode_w : mode_a;
  assign toff_e  = (toff_a == '0) ? 1 : int'(toff_a);

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    pulse_d = '0;
    deion_d = 1'b0;
    done_d  = 1'b0;
    if (state_nx == ON) begin
      pulse_d = mode_nx ? (N_CH'(1) << ptr_nx) : mask_nx;
    end else if (state_nx == OFF) begin
      deion_d = (int'(cnt_nx) >= DEAD) && (int'(cnt_nx) + DEAD + 1 <= toff_e);
      done_d  = (cnt_nx == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      ton_s       <= CNT_W'(PG_TON_RST);
      toff_s      <= CNT_W'(PG_TOFF_RST);
      mask_s      <= '1;
      mode_s      <= PG_MODE_RST;
      toff_a      <= CNT_W'(PG_TOFF_RST);
      mask_a      <= '1;
      mode_a      <= PG_MODE_RST;
      pulse       <= '0;
      deion       <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ptr         <= ptr_nx;
      ton_s       <= ton_w;
      toff_s      <= toff_w;
      mask_s      <= mask_w;
      mode_s      <= mode_w;
      toff_a      <= toff_nx;
      mask_a      <= mask_nx;
      mode_a      <= mode_nx;
      pulse       <= pulse_d;
      deion       <= deion_d;
      period_done <= done_d;
    end
  end

  assign is_operation = (state != IDLE);

endmodule
